button_debounce: RTL and testbench

//  Input-side counterpart of the LED output path: turns one raw, bouncing, asynchronous

---
 rtl/button_pkg.sv | 18 +
 rtl/sync_2ff.sv | 24 ++
 rtl/button_debounce.sv | 124 ++++++++++++
 tb/tb_button_debounce.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button debouncer.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_e;

  // Timer must hold the larger of the debounce and long-press spans without wrapping.
  function automatic int timer_width(input int debounce_cycles, input int long_cycles);
    int span;
    span = (debounce_cycles > long_cycles) ? debounce_cycles : long_cycles;
    return $clog2(span + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous board input; reset value is the pin's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: clocked logic uses non-blocking (<=) so both flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces one raw push-button pin into registered level, press/release pulses and a press count.
// Optional long-hold pulse on btn_long is built only when LONG_PRESS_EN is defined.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int LONG_CYCLES     = 25_000_000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  output logic             btn_level,
  output logic             btn_press,
  output logic             btn_release,
  output logic [CNT_W-1:0] press_count,
  output logic             btn_long
);

  localparam int               TIMER_W  = timer_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [TIMER_W-1:0] DEB_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             PIN_IDLE = (ACTIVE_LOW != 0);

  logic               pin_sync;
  logic               p;
  btn_state_e         state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               level_next, press_next, release_next;

  sync_2ff #(.RESET_VAL(PIN_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (pin_sync)
  );

  assign p = (ACTIVE_LOW != 0) ? ~pin_sync : pin_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    timer_next = '0;
    case (state)
      RELEASED: begin
        if (p) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!p)                    state_next = RELEASED;
        else if (timer == DEB_LAST) state_next = PRESSED;
        else                       timer_next = timer + 1'b1;
      end
      PRESSED: begin
        if (!p) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (p)                     state_next = PRESSED;
        else if (timer == DEB_LAST) state_next = RELEASED;
        else                       timer_next = timer + 1'b1;
      end
      default: state_next = RELEASED;
    endcase
  end

  // Output registers load from the next-state decision so pulses align with the accepting edge.
  always_comb begin
    level_next   = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    press_next   = (state == PRESS_WAIT)   && (state_next == PRESSED);
    release_next = (state == RELEASE_WAIT) && (state_next == RELEASED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      press_count <= '0;
    end else begin
      btn_level   <= level_next;
      btn_press   <= press_next;
      btn_release <= release_next;
      if (press_next) press_count <= press_count + 1'b1;
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LONG_DONE = TIMER_W'(LONG_CYCLES);

  logic [TIMER_W-1:0] hold;
  logic               long_q;

  // Hold timer parks at LONG_DONE so it fires once; only a fresh accepted press clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_next) begin
        hold <= '0;
      end else if (((state == PRESSED) || (state == RELEASE_WAIT)) && (hold != LONG_DONE)) begin
        hold   <= hold + 1'b1;
        long_q <= (hold == LONG_LAST);
      end
    end
  end

  assign btn_long = long_q;
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios plus randomized pin traffic vs a run-length model.
module tb_button_debounce;

  localparam int D  = 4;
  localparam int L  = 20;
  localparam int CW = 8;
`ifdef LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_in = 1'b1;
  logic          btn_level, btn_press, btn_release, btn_long;
  logic [CW-1:0] press_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .ACTIVE_LOW     (1),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .press_count (press_count),
    .btn_long    (btn_long)
  );

  // Reference: a level flips once the pressed value has differed from it for D+1 consecutive samples.
  logic pin_d1, pin_d2, m_p;
  logic m_level, m_press, m_release, m_long;
  int   m_run, m_age, m_presses;

  always @(posedge clk) begin
    if (rst) begin
      pin_d1 = 1'b1; pin_d2 = 1'b1;
      m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
      m_run = 0; m_age = 0; m_presses = 0;
    end else begin
      m_p    = !pin_d2;
      pin_d2 = pin_d1;
      pin_d1 = btn_in;
      m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
      if (m_level && m_age < L) begin
        m_age = m_age + 1;
        if (m_age == L) m_long = LONG_ON;
      end
      if (m_p != m_level) m_run = m_run + 1;
      else                m_run = 0;
      if (m_run == D + 1) begin
        m_level = m_p;
        m_run   = 0;
        if (m_p) begin
          m_press   = 1'b1;
          m_presses = m_presses + 1;
          m_age     = 0;
        end else begin
          m_release = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input logic pin);
    btn_in = pin;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b1);
    cyc(1'b1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc(1'b1);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_long, press_count} !== '0)
        $display("FAIL reset_hold k=%0d got lvl=%b prs=%b rel=%b long=%b cnt=%0d want all 0",
                 k, btn_level, btn_press, btn_release, btn_long, press_count);
      else n_pass++;
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_long, press_count} !== '0)
        $display("FAIL reset_idle k=%0d got lvl=%b prs=%b rel=%b cnt=%0d want all 0",
                 k, btn_level, btn_press, btn_release, press_count);
      else n_pass++;
    end
  endtask

  task automatic test_press();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0);
      n_checks++;
      if (btn_press !== (k == 7) || btn_level !== (k >= 7) || press_count !== ((k >= 7) ? 8'd1 : 8'd0))
        $display("FAIL press_latency clk=%0d got prs=%b lvl=%b cnt=%0d want prs=%b lvl=%b cnt=%0d",
                 k, btn_press, btn_level, press_count, (k == 7), (k >= 7), (k >= 7) ? 1 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      for (int k = 0; k < w + 10; k++) begin
        cyc(k < w ? 1'b0 : 1'b1);
        n_checks++;
        if (btn_press !== 1'b0 || btn_level !== 1'b0 || press_count !== 8'd0)
          $display("FAIL glitch w=%0d k=%0d got prs=%b lvl=%b cnt=%0d want 0/0/0",
                   w, k, btn_press, btn_level, press_count);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bouncy_release();
    int releases;
    do_reset();
    repeat (12) cyc(1'b0);
    n_checks++;
    if (btn_level !== 1'b1 || press_count !== 8'd1)
      $display("FAIL bounce_setup got lvl=%b cnt=%0d want 1/1", btn_level, press_count);
    else n_pass++;
    releases = 0;
    cyc(1'b1);
    releases += int'(btn_release);
    cyc(1'b0);
    releases += int'(btn_release);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1);
      releases += int'(btn_release);
      n_checks++;
      if (btn_release !== (k == 7) || btn_press !== 1'b0 || btn_level !== (k < 7) || press_count !== 8'd1)
        $display("FAIL bounce_release clk=%0d got rel=%b prs=%b lvl=%b cnt=%0d want rel=%b prs=0 lvl=%b cnt=1",
                 k, btn_release, btn_press, btn_level, press_count, (k == 7), (k < 7));
      else n_pass++;
    end
    n_checks++;
    if (releases != 1) $display("FAIL bounce_release_count got %0d want 1", releases);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [CW-1:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      exp_cnt = CW'((i + 1) % 256);
      for (int j = 1; j <= 16; j++) begin
        cyc(j <= 8 ? 1'b0 : 1'b1);
        n_checks++;
        if (btn_press !== (j == 7) || btn_release !== (j == 15) ||
            (j >= 7 && press_count !== exp_cnt))
          $display("FAIL wrap press=%0d clk=%0d got prs=%b rel=%b cnt=%0d want prs=%b rel=%b cnt=%0d",
                   i, j, btn_press, btn_release, press_count, (j == 7), (j == 15), exp_cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_long();
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b0);
      n_checks++;
      if (btn_long !== (LONG_ON && k == 7 + L))
        $display("FAIL long_pulse clk=%0d got %b want %b", k, btn_long, (LONG_ON && k == 7 + L));
      else n_pass++;
    end
    repeat (10) cyc(1'b1);
    for (int k = 1; k <= 15; k++) cyc(1'b0);
    rst = 1'b1;
    cyc(1'b0);
    n_checks++;
    if ({btn_level, btn_press, btn_release, btn_long, press_count} !== '0)
      $display("FAIL long_mid_reset got lvl=%b prs=%b rel=%b long=%b cnt=%0d want all 0",
               btn_level, btn_press, btn_release, btn_long, press_count);
    else n_pass++;
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b0);
      n_checks++;
      if (btn_long !== m_long || btn_level !== m_level || btn_press !== m_press || press_count !== CW'(m_presses % 256))
        $display("FAIL long_after_reset clk=%0d got long=%b lvl=%b prs=%b cnt=%0d want %b %b %b %0d",
                 k, btn_long, btn_level, btn_press, press_count, m_long, m_level, m_press, m_presses % 256);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic pin;
    int   len;
    do_reset();
    for (int seg = 0; seg < 500; seg++) begin
      pin = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        rst = ($urandom_range(0, 299) == 0);
        cyc(pin);
        n_checks++;
        if (btn_level !== m_level || btn_press !== m_press || btn_release !== m_release ||
            btn_long !== m_long || press_count !== CW'(m_presses % 256) || (btn_press && btn_release))
          $display("FAIL random seg=%0d got lvl=%b prs=%b rel=%b long=%b cnt=%0d want %b %b %b %b %0d",
                   seg, btn_level, btn_press, btn_release, btn_long, press_count,
                   m_level, m_press, m_release, m_long, m_presses % 256);
        else n_pass++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_press();
    test_glitch();
    test_bouncy_release();
    test_wrap();
    test_long();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
